// File: rtl/fitness_engine.sv
// Multi-lane GA fitness evaluator: scores LANES genes per cycle, returns the result
// over valid/ready and tracks the lowest fitness seen since clear/reset.
module fitness_engine #(
  parameter int GENOME_LENGTH = 28,
  parameter int GENE_WIDTH    = 8,
  parameter int LANES         = 4,
  parameter int FIT_WIDTH     = 13,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [1:0]                               mode,
  input  logic [TAG_WIDTH-1:0]                     tag,
  input  logic [GENOME_LENGTH-1:0][GENE_WIDTH-1:0] chromosome,
  input  logic [GENOME_LENGTH-1:0][GENE_WIDTH-1:0] target,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [FIT_WIDTH-1:0]                     fitness,
  output logic [TAG_WIDTH-1:0]                     out_tag,
  input  logic                                     best_clear,
  output logic                                     best_valid,
  output logic [FIT_WIDTH-1:0]                     best_fitness,
  output logic [TAG_WIDTH-1:0]                     best_tag
);

  localparam int BEATS  = (GENOME_LENGTH + LANES - 1) / LANES;
  localparam int PAD_W  = BEATS * LANES * GENE_WIDTH;
  localparam int SHIFT  = LANES * GENE_WIDTH;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [PAD_W-1:0]     chrom_q, targ_q;
  logic [1:0]           mode_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [BW-1:0]        beat_q;
  logic [FIT_WIDTH-1:0] acc_q, beat_sum;
  logic [FIT_WIDTH-1:0] fitness_q, best_fitness_q;
  logic [TAG_WIDTH-1:0] out_tag_q, best_tag_q;
  logic                 best_valid_q;
  logic                 accept, consume, last_beat;

  function automatic logic [FIT_WIDTH-1:0] lane_score(input logic [1:0] m,
                                                      input logic [GENE_WIDTH-1:0] c,
                                                      input logic [GENE_WIDTH-1:0] t);
    logic [GENE_WIDTH-1:0] x, d;
    x = c ^ t;
    d = (c >= t) ? (c - t) : (t - c);
    case (m)
      2'd1:    return FIT_WIDTH'($countones(x));
      2'd2:    return FIT_WIDTH'(d);
      default: return FIT_WIDTH'(c != t);
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign last_beat = (state_q == RUN) && (beat_q == LAST_BEAT);

  // Operands are zero-padded to a whole number of beats, so padded lanes
  // compare 0 against 0 and contribute nothing in every mode.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + lane_score(mode_q, chrom_q[l*GENE_WIDTH +: GENE_WIDTH],
                                       targ_q[l*GENE_WIDTH +: GENE_WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chrom_q   <= '0;
      targ_q    <= '0;
      mode_q    <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      acc_q     <= '0;
      fitness_q <= '0;
      out_tag_q <= '0;
    end else if (accept) begin
      chrom_q <= PAD_W'(chromosome);
      targ_q  <= PAD_W'(target);
      mode_q  <= mode;
      tag_q   <= tag;
      beat_q  <= '0;
      acc_q   <= '0;
    end else if (state_q == RUN) begin
      chrom_q <= chrom_q >> SHIFT;
      targ_q  <= targ_q >> SHIFT;
      acc_q   <= acc_q + beat_sum;
      beat_q  <= beat_q + 1'b1;
      if (last_beat) begin
        fitness_q <= acc_q + beat_sum;
        out_tag_q <= tag_q;
      end
    end
  end

  // A clear coinciding with a consume makes the consumed result the new best.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_valid_q   <= 1'b0;
      best_fitness_q <= '0;
      best_tag_q     <= '0;
    end else if (consume && (best_clear || !best_valid_q || fitness_q < best_fitness_q)) begin
      best_valid_q   <= 1'b1;
      best_fitness_q <= fitness_q;
      best_tag_q     <= out_tag_q;
    end else if (best_clear) begin
      best_valid_q   <= 1'b0;
      best_fitness_q <= '0;
      best_tag_q     <= '0;
    end
  end

  assign fitness      = fitness_q;
  assign out_tag      = out_tag_q;
  assign best_valid   = best_valid_q;
  assign best_fitness = best_fitness_q;
  assign best_tag     = best_tag_q;

endmodule

// File: tb/tb_fitness_engine.sv
// Directed bench for fitness_engine: default 4-lane instance plus a 5-lane instance.
module tb_fitness_engine;
  localparam int GL = 28;
  localparam int FW = 13;
  localparam int TW = 8;

  typedef logic [GL-1:0][7:0] genes_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, out_ready = 1'b0, best_clear = 1'b0;
  logic          in_ready, out_valid, best_valid;
  logic [1:0]    mode = 2'd0;
  logic [TW-1:0] tag = '0, out_tag, best_tag;
  genes_t        chromosome = '0, target = '0;
  logic [FW-1:0] fitness, best_fitness;

  logic          in_valid5 = 1'b0, out_ready5 = 1'b0;
  logic          in_ready5, out_valid5, best_valid5;
  logic [TW-1:0] out_tag5, best_tag5;
  logic [FW-1:0] fitness5, best_fitness5;

  int n_cmp = 0;
  int n_bad = 0;

  fitness_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .tag(tag),
    .chromosome(chromosome), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .fitness(fitness), .out_tag(out_tag), .best_clear(best_clear), .best_valid(best_valid),
    .best_fitness(best_fitness), .best_tag(best_tag)
  );

  fitness_engine #(.LANES(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .mode(mode), .tag(tag),
    .chromosome(chromosome), .target(target), .out_valid(out_valid5), .out_ready(out_ready5),
    .fitness(fitness5), .out_tag(out_tag5), .best_clear(1'b0), .best_valid(best_valid5),
    .best_fitness(best_fitness5), .best_tag(best_tag5)
  );

  function automatic genes_t fill(input logic [7:0] v);
    genes_t g;
    for (int i = 0; i < GL; i++) g[i] = v;
    return g;
  endfunction

  // k leading genes set to 0x77 against an all-zero target: mode 0 score is k
  function automatic genes_t ndiff(input int k);
    genes_t g;
    for (int i = 0; i < GL; i++) g[i] = (i < k) ? 8'h77 : 8'h00;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, completes the handshake, then scrambles the inputs
  task automatic accept(input logic [1:0] m, input logic [TW-1:0] tg, input genes_t c, input genes_t t);
    mode = m; tag = tg; chromosome = c; target = t; in_valid = 1'b1;
    #1;
    for (int g = 0; g < 50 && !in_ready; g++) tick();
    tick();
    in_valid = 1'b0;
    chromosome = ~c; target = ~c ^ t; tag = ~tg; mode = m + 2'd1;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0d want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
    n_cmp++; if (fitness !== '0 || out_tag !== '0) begin n_bad++; $display("FAIL reset_result: got %0d/%0d want 0/0", fitness, out_tag); end
    n_cmp++; if (best_valid !== 1'b0 || best_fitness !== '0 || best_tag !== '0) begin n_bad++; $display("FAIL reset_best: got %0d/%0d/%0d want 0/0/0", best_valid, best_fitness, best_tag); end
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mismatch();
    genes_t c, t;
    int cyc;
    t = fill(8'h5A);
    c = t;
    c[0]  = 8'h5B;
    c[27] = 8'h00;
    accept(2'd0, 8'hA5, c, t);
    wait_result(cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL mismatch_latency: got %0d want 7", cyc); end
    n_cmp++; if (fitness !== 13'd2) begin n_bad++; $display("FAIL mismatch_fitness: got %0d want 2", fitness); end
    n_cmp++; if (out_tag !== 8'hA5) begin n_bad++; $display("FAIL mismatch_tag: got %0h want a5", out_tag); end
    consume();
  endtask

  task automatic test_modes();
    logic [1:0]    m_t [5] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [7:0]    c_t [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h10};
    logic [7:0]    t_t [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h30};
    logic [FW-1:0] e_t [5] = '{13'd7140, 13'd224, 13'd28, 13'd28, 13'd896};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      accept(m_t[i], 8'(8'h10 + i), fill(c_t[i]), fill(t_t[i]));
      wait_result(cyc);
      n_cmp++; if (out_valid !== 1'b1 || fitness !== e_t[i]) begin n_bad++; $display("FAIL modes[%0d]: got valid %0d fitness %0d want 1/%0d", i, out_valid, fitness, e_t[i]); end
      consume();
    end
  endtask

  task automatic test_lanes5();
    genes_t c, t;
    logic [FW-1:0] e_t [2] = '{13'd1, 13'd7140};
    logic [1:0]    m_t [2] = '{2'd0, 2'd2};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      t = (i == 0) ? fill(8'h3C) : fill(8'h00);
      c = (i == 0) ? t : fill(8'hFF);
      if (i == 0) c[27] = 8'h3D;
      mode = m_t[i]; tag = 8'(8'hC0 + i); chromosome = c; target = t; in_valid5 = 1'b1;
      #1;
      n_cmp++; if (in_ready5 !== 1'b1) begin n_bad++; $display("FAIL lanes5_ready[%0d]: got %0d want 1", i, in_ready5); end
      tick();
      in_valid5 = 1'b0;
      chromosome = ~c;
      cyc = 0;
      while (!out_valid5 && cyc < 100) begin
        tick();
        cyc++;
      end
      n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL lanes5_latency[%0d]: got %0d want 6", i, cyc); end
      n_cmp++; if (fitness5 !== e_t[i]) begin n_bad++; $display("FAIL lanes5_fitness[%0d]: got %0d want %0d", i, fitness5, e_t[i]); end
      n_cmp++; if (out_tag5 !== 8'(8'hC0 + i)) begin n_bad++; $display("FAIL lanes5_tag[%0d]: got %0h want %0h", i, out_tag5, 8'hC0 + i); end
      out_ready5 = 1'b1;
      tick();
      out_ready5 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    accept(2'd0, 8'h44, ndiff(3), fill(8'h00));
    wait_result(cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL hold_latency: got %0d want 7", cyc); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || fitness !== 13'd3 || out_tag !== 8'h44) begin
        n_bad++; $display("FAIL hold[%0d]: got valid %0d ready %0d fitness %0d tag %0h want 1/0/3/44", i, out_valid, in_ready, fitness, out_tag);
      end
      tick();
    end
    mode = 2'd1; tag = 8'h55; chromosome = fill(8'h01); target = fill(8'h00);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %0d want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0; chromosome = fill(8'hFF);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_consumed: got %0d want 0", out_valid); end
    wait_result(cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL b2b_latency: got %0d want 7", cyc); end
    n_cmp++; if (fitness !== 13'd28 || out_tag !== 8'h55) begin n_bad++; $display("FAIL b2b_result: got %0d/%0h want 28/55", fitness, out_tag); end
    consume();
  endtask

  task automatic test_best();
    int k_t [4] = '{5, 3, 3, 9};
    int cyc;
    best_clear = 1'b1;
    tick();
    best_clear = 1'b0;
    n_cmp++; if (best_valid !== 1'b0 || best_fitness !== '0 || best_tag !== '0) begin n_bad++; $display("FAIL best_clear: got %0d/%0d/%0d want 0/0/0", best_valid, best_fitness, best_tag); end
    for (int i = 0; i < 4; i++) begin
      accept(2'd0, 8'(i + 1), ndiff(k_t[i]), fill(8'h00));
      wait_result(cyc);
      n_cmp++; if (fitness !== 13'(k_t[i])) begin n_bad++; $display("FAIL best_seq[%0d]: got %0d want %0d", i, fitness, k_t[i]); end
      consume();
    end
    n_cmp++; if (best_valid !== 1'b1 || best_fitness !== 13'd3 || best_tag !== 8'd2) begin n_bad++; $display("FAIL best_track: got %0d/%0d/%0d want 1/3/2", best_valid, best_fitness, best_tag); end
    accept(2'd0, 8'd4, ndiff(9), fill(8'h00));
    wait_result(cyc);
    best_clear = 1'b1;
    consume();
    best_clear = 1'b0;
    n_cmp++; if (best_valid !== 1'b1 || best_fitness !== 13'd9 || best_tag !== 8'd4) begin n_bad++; $display("FAIL best_clear_consume: got %0d/%0d/%0d want 1/9/4", best_valid, best_fitness, best_tag); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic seen;
    accept(2'd2, 8'h66, fill(8'hFF), fill(8'h00));
    repeat (2) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_handshake: got valid %0d ready %0d want 0/1", out_valid, in_ready); end
    n_cmp++; if (fitness !== '0 || out_tag !== '0) begin n_bad++; $display("FAIL abort_result: got %0d/%0h want 0/0", fitness, out_tag); end
    n_cmp++; if (best_valid !== 1'b0 || best_fitness !== '0 || best_tag !== '0) begin n_bad++; $display("FAIL abort_best: got %0d/%0d/%0d want 0/0/0", best_valid, best_fitness, best_tag); end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result: got %0d want 0", seen); end
    accept(2'd1, 8'h77, fill(8'h03), fill(8'h00));
    wait_result(cyc);
    n_cmp++; if (cyc !== 7 || fitness !== 13'd56 || out_tag !== 8'h77) begin n_bad++; $display("FAIL post_reset: got lat %0d fitness %0d tag %0h want 7/56/77", cyc, fitness, out_tag); end
    consume();
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_modes();
    test_lanes5();
    test_back_to_back();
    test_best();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fitness_engine.md
Name: fitness_engine

Overview:
Multi-lane, multi-mode fitness evaluator for the GA datapath. It captures one chromosome/target pair through a valid/ready handshake. It then compares LANES genes per cycle and returns a scored result through a second valid/ready handshake. It also tracks the best (lowest) fitness and its tag across evaluations, and sits between the population memory and the selection unit.

Parameters:
GENOME_LENGTH, 28, number of genes per chromosome (>=1)
GENE_WIDTH, 8, bits per gene (>=1)
LANES, 4, genes compared per cycle (1..GENOME_LENGTH)
FIT_WIDTH, 13, fitness width; must hold GENOME_LENGTH*(2**GENE_WIDTH-1)
TAG_WIDTH, 8, width of the caller-supplied chromosome tag

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  request accepted when in_valid & in_ready at rising clk
mode  in  2  0=gene mismatch count, 1=bit Hamming distance, 2=sum of |chrom-target|, 3=reserved (behaves as 0)
tag  in  TAG_WIDTH  chromosome identifier
chromosome  in  [GENE_WIDTH] x GENOME_LENGTH  genes to score
target  in  [GENE_WIDTH] x GENOME_LENGTH  reference genes
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
fitness  out  FIT_WIDTH  score, lower is better
out_tag  out  TAG_WIDTH  tag of scored chromosome
best_clear  in  1  synchronous clear of best tracker
best_valid  out  1  best tracker holds a value
best_fitness  out  FIT_WIDTH  lowest fitness consumed since clear/reset
best_tag  out  TAG_WIDTH  tag of best_fitness

Behaviour:
- Reset (async): state IDLE; in_ready=1; out_valid=0; fitness, out_tag, best_fitness, best_tag, best_valid, accumulator and beat index all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN on accept:
  - chromosome, target, mode and tag are registered; later input changes are ignored.
  - Accumulator and beat index are cleared.
- RUN: each cycle processes beat b (genes b*LANES .. b*LANES+LANES-1) and adds the per-lane contributions to the accumulator.
  - Lanes with index >= GENOME_LENGTH are masked and contribute 0.
  - BEATS = ceil(GENOME_LENGTH/LANES).
  - On the last beat, the final sum (including that beat) loads fitness and out_tag, and the state goes to DONE.
  - Every gene, including the last, is counted exactly once.
- Per-lane contribution:
  - mode 0/3: 1 if genes differ, else 0.
  - mode 1: popcount(chrom XOR target).
  - mode 2: |chrom-target| as unsigned.
  - Accumulation is unsigned with no saturation; FIT_WIDTH sizing guarantees no overflow.
- Latency: out_valid rises exactly BEATS cycles after the accept edge (7 cycles at the defaults).
- DONE: out_valid=1; fitness and out_tag are held stable until out_ready.
  - On consume: go to IDLE; or go directly to RUN if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back throughput is one result every BEATS+1 cycles without bubbles beyond DONE.
- in_valid during RUN is not accepted; the requester must hold its request.
- Best tracker (updated on result consume):
  - If !best_valid or fitness < best_fitness (strict), load best_fitness/best_tag and set best_valid.
  - On ties, the earlier result is kept.
- best_clear: clears best_valid, best_fitness and best_tag on the next edge.
  - If a consume occurs in the same cycle, clear is applied first and the consumed result becomes the new best (best_valid=1).
- Reset mid-RUN or mid-DONE aborts the evaluation; the result is lost and no out_valid pulse appears.

Test Plan:
1. Defaults, mode 0, chromosome = target except genes 0 and 27 differ → out_valid 7 cycles after accept, fitness=2 (checks last gene counted), out_tag = input tag.
2. Mode 2, all target=0x00 and all chromosome=0xFF → fitness=28*255=7140; mode 1 same data → fitness=224; mode 3 → fitness=28.
3. GENOME_LENGTH=28, LANES=5 (6 beats, last partial), only gene 27 differs → fitness=1 after 6 cycles; masked lanes contribute 0.
4. Hold out_ready=0 for 10 cycles in DONE → fitness and out_tag stable, in_ready=0. Then out_ready=1 with in_valid=1 → consume and accept on the same edge, next result 7 cycles later.
5. Best tracking: results 5 (tag 1), 3 (tag 2), 3 (tag 3), 9 (tag 4) → best_fitness=3, best_tag=2. best_clear with a concurrent consume of 9 → best=9, tag 4, best_valid=1.
6. Assert rst 3 cycles into RUN → all outputs 0 and in_ready=1 asynchronously, no out_valid afterward. A fresh request after reset scores correctly.
